// File: rtl/param_mem.sv
// Parameterised single-port-pair RAM that self-clears after reset, with registered reads.
// Optional per-word even parity is compiled in with `define PARAM_MEM_PARITY_EN.
module param_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
`ifdef PARAM_MEM_PARITY_EN
   input  logic              inj_par_err,
`endif
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   output logic              busy
);

   typedef enum logic {INIT, READY} state_e;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] clr_ptr_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              rd_err_q;

   logic wr_in_range, rd_in_range;
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

`ifdef PARAM_MEM_PARITY_EN
   logic mem_par_q [DEPTH];
   logic par_bad;
   // Stored bit makes the word+parity XOR to zero; any other value flags corruption.
   assign par_bad = (^mem_q[rd_addr]) ^ mem_par_q[rd_addr];
`else
   logic par_bad;
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT;
         clr_ptr_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         case (state_q)
            INIT: begin
               mem_q[clr_ptr_q] <= '0;
`ifdef PARAM_MEM_PARITY_EN
               mem_par_q[clr_ptr_q] <= 1'b0;
`endif
               clr_ptr_q <= clr_ptr_q + 1'b1;
               if (clr_ptr_q == LAST_C) state_q <= READY;
            end
            READY: begin
               // Read samples the old word, so a same-address write is read-first.
               if (rd_en) begin
                  rd_valid_q <= 1'b1;
                  if (rd_in_range) begin
                     rd_data_q <= mem_q[rd_addr];
                     rd_err_q  <= par_bad;
                  end else begin
                     rd_err_q  <= 1'b1;
                  end
               end
               if (wr_en && wr_in_range) begin
                  mem_q[wr_addr] <= wr_data;
`ifdef PARAM_MEM_PARITY_EN
                  mem_par_q[wr_addr] <= (^wr_data) ^ inj_par_err;
`endif
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign busy     = (state_q == INIT);

endmodule

// File: tb/tb_param_mem.sv
// Randomised self-checking bench for param_mem: default instance plus a DEPTH=12 instance
// sharing clock and reset, each compared against a plain array model.
module tb_param_mem;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en;
   logic [3:0] wr_addr, rd_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       rd_valid, rd_err, busy;
   logic       inj;

   logic       wr_en12, rd_en12;
   logic [3:0] wr_addr12, rd_addr12;
   logic [7:0] wr_data12;
   logic [7:0] rd_data12;
   logic       rd_valid12, rd_err12, busy12;

   int n_vec = 0;
   int n_err = 0;

   int model   [16];
   int model12 [12];

   always #5 clk = ~clk;

   param_mem dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef PARAM_MEM_PARITY_EN
      .inj_par_err(inj),
`endif
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .busy(busy)
   );

   param_mem #(.DATA_W(8), .DEPTH(12), .ADDR_W(4)) dut12 (
      .clk(clk), .rst(rst),
      .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12),
`ifdef PARAM_MEM_PARITY_EN
      .inj_par_err(1'b0),
`endif
      .rd_en(rd_en12), .rd_addr(rd_addr12),
      .rd_data(rd_data12), .rd_valid(rd_valid12), .rd_err(rd_err12), .busy(busy12)
   );

   // Inputs are changed and outputs sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; rd_en = 0; inj = 0; wr_en12 = 0; rd_en12 = 0;
   endtask

   // Returns the number of cycles busy stayed high after reset release, bounded.
   task automatic reset_and_count(output int cnt);
      rst = 1'b1;
      step();
      rst = 1'b0;
      cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL init_no_valid: rd_valid=%b required 0", rd_valid);
         end
         n_vec++;
         step();
      end
      idle();
      for (int i = 0; i < 16; i++) model[i] = 0;
      for (int i = 0; i < 12; i++) model12[i] = 0;
   endtask

   task automatic test_reset();
      int cnt;
      idle();
      rst = 1'b1;
      step();
      n_vec++;
      if ({busy, rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset_outputs: busy=%b valid=%b err=%b data=%h required 1 0 0 00",
                  busy, rd_valid, rd_err, rd_data);
      end
      reset_and_count(cnt);
      n_vec++;
      if (cnt !== 16) begin
         n_err++;
         $display("FAIL busy_cycles: got %0d required 16", cnt);
      end
      rd_en = 1; rd_addr = 5;
      step();
      rd_en = 0;
      n_vec++;
      if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL read_after_init: valid=%b err=%b data=%h required 1 0 00",
                  rd_valid, rd_err, rd_data);
      end
      step();
      n_vec++;
      if ({rd_valid, rd_err, rd_data} !== 10'b0) begin
         n_err++;
         $display("FAIL idle_outputs: valid=%b err=%b data=%h required 0 0 00",
                  rd_valid, rd_err, rd_data);
      end
   endtask

   task automatic test_write_read();
      wr_en = 1; wr_addr = 3; wr_data = 8'hA5; model[3] = 'hA5;
      step();
      wr_en = 0; rd_en = 1; rd_addr = 3;
      step();
      rd_en = 0;
      n_vec++;
      if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 8'hA5}) begin
         n_err++;
         $display("FAIL write_read: valid=%b err=%b data=%h required 1 0 a5",
                  rd_valid, rd_err, rd_data);
      end
   endtask

   task automatic test_read_first();
      wr_en = 1; wr_addr = 7; wr_data = 8'h11;
      step();
      wr_data = 8'h22; rd_en = 1; rd_addr = 7;
      step();
      wr_en = 0;
      n_vec++;
      if ({rd_valid, rd_data} !== {1'b1, 8'h11}) begin
         n_err++;
         $display("FAIL read_first_old: valid=%b data=%h required 1 11", rd_valid, rd_data);
      end
      step();
      rd_en = 0;
      model[7] = 'h22;
      n_vec++;
      if ({rd_valid, rd_data} !== {1'b1, 8'h22}) begin
         n_err++;
         $display("FAIL read_first_new: valid=%b data=%h required 1 22", rd_valid, rd_data);
      end
   endtask

   task automatic test_out_of_range();
      wr_en12 = 1; wr_addr12 = 13; wr_data12 = 8'hFF;
      step();
      wr_en12 = 0; rd_en12 = 1; rd_addr12 = 13;
      step();
      n_vec++;
      if ({rd_valid12, rd_err12, rd_data12} !== {1'b1, 1'b1, 8'h00}) begin
         n_err++;
         $display("FAIL oor_read: valid=%b err=%b data=%h required 1 1 00",
                  rd_valid12, rd_err12, rd_data12);
      end
      for (int a = 0; a < 12; a++) begin
         rd_addr12 = 4'(a);
         step();
         n_vec++;
         if ({rd_valid12, rd_err12, rd_data12} !== {1'b1, 1'b0, 8'(model12[a])}) begin
            n_err++;
            $display("FAIL oor_contents[%0d]: valid=%b err=%b data=%h required 1 0 %h",
                     a, rd_valid12, rd_err12, rd_data12, 8'(model12[a]));
         end
      end
      rd_en12 = 0;
   endtask

   task automatic test_random();
      bit         exp_v, exp_e;
      logic [7:0] exp_d;
      for (int c = 0; c < 300; c++) begin
         wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 8'($urandom);
         rd_en = 1'($urandom); rd_addr = 4'($urandom);
         wr_en12 = 1'($urandom); wr_addr12 = 4'($urandom); wr_data12 = 8'($urandom);
         rd_en12 = 1'($urandom); rd_addr12 = 4'($urandom);
         exp_v = rd_en;  exp_e = 1'b0;
         exp_d = rd_en ? 8'(model[rd_addr]) : 8'h00;
         step();
         n_vec++;
         if ({rd_valid, rd_err, rd_data} !== {exp_v, exp_e, exp_d}) begin
            n_err++;
            $display("FAIL random16[%0d]: valid=%b err=%b data=%h required %b %b %h",
                     c, rd_valid, rd_err, rd_data, exp_v, exp_e, exp_d);
         end
         n_vec++;
         if (rd_en12) begin
            exp_e = (rd_addr12 >= 12);
            exp_d = exp_e ? 8'h00 : 8'(model12[rd_addr12]);
         end else begin
            exp_e = 1'b0; exp_d = 8'h00;
         end
         if ({rd_valid12, rd_err12, rd_data12} !== {rd_en12, exp_e, exp_d}) begin
            n_err++;
            $display("FAIL random12[%0d]: valid=%b err=%b data=%h required %b %b %h",
                     c, rd_valid12, rd_err12, rd_data12, rd_en12, exp_e, exp_d);
         end
         if (wr_en) model[wr_addr] = int'(wr_data);
         if (wr_en12 && wr_addr12 < 12) model12[wr_addr12] = int'(wr_data12);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 16; a++) begin
         rd_en = 1; rd_addr = 4'(a);
         wr_en = 1; wr_addr = 4'(15 - a); wr_data = 8'(a * 7 + 1);
         step();
         n_vec++;
         if ({rd_valid, rd_data} !== {1'b1, 8'(model[a])}) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: valid=%b data=%h required 1 %h",
                     a, rd_valid, rd_data, 8'(model[a]));
         end
         model[15 - a] = a * 7 + 1;
      end
      idle();
   endtask

   task automatic test_reset_midsweep();
      int cnt;
      wr_en = 1; wr_addr = 9; wr_data = 8'h5A;
      step();
      wr_en = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      rd_en = 1; rd_addr = 9;
      for (int i = 0; i < 8; i++) begin
         step();
         n_vec++;
         if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_no_valid[%0d]: rd_valid=%b required 0", i, rd_valid);
         end
      end
      reset_and_count(cnt);
      n_vec++;
      if (cnt !== 16) begin
         n_err++;
         $display("FAIL midsweep_busy: got %0d required 16", cnt);
      end
      rd_en = 1; rd_addr = 9;
      step();
      rd_en = 0;
      n_vec++;
      if ({rd_valid, rd_data} !== {1'b1, 8'h00}) begin
         n_err++;
         $display("FAIL midsweep_cleared: valid=%b data=%h required 1 00", rd_valid, rd_data);
      end
   endtask

`ifdef PARAM_MEM_PARITY_EN
   task automatic test_parity();
      wr_en = 1; wr_addr = 2; wr_data = 8'h3C; inj = 1;
      step();
      wr_en = 0; inj = 0; rd_en = 1; rd_addr = 2;
      step();
      rd_en = 0;
      n_vec++;
      if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b1, 8'h3C}) begin
         n_err++;
         $display("FAIL parity_inj: valid=%b err=%b data=%h required 1 1 3c",
                  rd_valid, rd_err, rd_data);
      end
      wr_en = 1;
      step();
      wr_en = 0; rd_en = 1;
      step();
      rd_en = 0;
      n_vec++;
      if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 8'h3C}) begin
         n_err++;
         $display("FAIL parity_clean: valid=%b err=%b data=%h required 1 0 3c",
                  rd_valid, rd_err, rd_data);
      end
      model[2] = 'h3C;
   endtask
`endif

   initial begin
      rst = 1'b0; wr_addr = 0; wr_data = 0; rd_addr = 0;
      wr_addr12 = 0; wr_data12 = 0; rd_addr12 = 0;
      idle();
      test_reset();
      test_write_read();
      test_read_first();
      test_out_of_range();
      test_random();
      test_back_to_back();
`ifdef PARAM_MEM_PARITY_EN
      test_parity();
`endif
      test_reset_midsweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
